// File: rtl/instr_pkg.sv
// Shared MIPS instruction-format constants, used by both the field packer and the field splitter.
package instr_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR0  = 3'd1,
    ST_WR1  = 3'd2,
    ST_WR2  = 3'd3,
    ST_WR3  = 3'd4
  } state_e;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SH_HI    = 10;
  localparam int SH_LO    = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int TGT_HI   = 25;
  localparam int TGT_LO   = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;

  // Byte lane written by each write state; WR0 carries the most significant byte.
  function automatic logic [1:0] wr_index(input state_e s);
    case (s)
      ST_WR1:  return 2'd1;
      ST_WR2:  return 2'd2;
      ST_WR3:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: decoded R/I/J fields plus format code in, 32-bit instruction word out.
module instr_field_pack
  import instr_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [5:0]  opcode_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        bad_o
);

  // An illegal format packs to all zeros (a nop) and is flagged to the caller.
  always_comb begin
    word_o = '0;
    bad_o  = 1'b0;
    case (fmt_i)
      FMT_R: begin
        word_o[OP_HI:OP_LO]       = opcode_i;
        word_o[RS_HI:RS_LO]       = rs_i;
        word_o[RT_HI:RT_LO]       = rt_i;
        word_o[RD_HI:RD_LO]       = rd_i;
        word_o[SH_HI:SH_LO]       = shamt_i;
        word_o[FUNCT_HI:FUNCT_LO] = funct_i;
      end
      FMT_I: begin
        word_o[OP_HI:OP_LO]   = opcode_i;
        word_o[RS_HI:RS_LO]   = rs_i;
        word_o[RT_HI:RT_LO]   = rt_i;
        word_o[IMM_HI:IMM_LO] = imm_i;
      end
      FMT_J: begin
        word_o[OP_HI:OP_LO]   = opcode_i;
        word_o[TGT_HI:TGT_LO] = target_i;
      end
      default: begin
        bad_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Packs decoded MIPS fields into instruction words and writes each one byte-serially,
// big-endian, into the 8-bit instruction memory port.
module instr_packer
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       fmt_i,
  input  logic [5:0]       opcode_i,
  input  logic [4:0]       rs_i,
  input  logic [4:0]       rt_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       shamt_i,
  input  logic [5:0]       funct_i,
  input  logic [15:0]      imm_i,
  input  logic [25:0]      target_i,
  input  logic             addr_load_i,
  input  logic [31:0]      addr_in_i,
  output logic             mem_wr_o,
  output logic [31:0]      mem_addr_o,
  output logic [7:0]       mem_data_o,
  output logic [31:0]      instr_word_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             busy_o,
  output logic             err_o
);

  state_e            state_q, state_d;
  logic [31:0]       ptr_q, ptr_d;
  logic [31:0]       word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mem_wr_q, mem_wr_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic [31:0]       packed_word;
  logic              packed_bad;
  logic [31:0]       load_addr;

  instr_field_pack u_pack (
    .fmt_i    (fmt_i),
    .opcode_i (opcode_i),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .rd_i     (rd_i),
    .shamt_i  (shamt_i),
    .funct_i  (funct_i),
    .imm_i    (imm_i),
    .target_i (target_i),
    .word_o   (packed_word),
    .bad_o    (packed_bad)
  );

  assign load_addr  = addr_in_i & ~32'h0000_0003;
  assign in_ready_o = (state_q == ST_IDLE) && !addr_load_i;

  // Memory-port outputs are registered, so they are derived from the state being entered.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    case (state_q)
      ST_IDLE: begin
        if (addr_load_i) begin
          ptr_d = load_addr;
        end else if (in_valid_i) begin
          state_d = ST_WR0;
          word_d  = packed_word;
          if (packed_bad) err_d = 1'b1;
        end
      end
      ST_WR0: state_d = ST_WR1;
      ST_WR1: state_d = ST_WR2;
      ST_WR2: state_d = ST_WR3;
      ST_WR3: begin
        state_d = ST_IDLE;
        ptr_d   = ptr_q + 32'd4;
        if (!(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != ST_IDLE) begin
      mem_wr_d   = 1'b1;
      mem_addr_d = ptr_q + {30'd0, wr_index(state_d)};
      mem_data_d = byte_sel(word_d, wr_index(state_d));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      ptr_q      <= BASE_ADDR;
      word_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_wr_o     = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign instr_word_o = word_q;
  assign instr_cnt_o  = cnt_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = err_q;

endmodule
